// File: rtl/itof_arbiter.sv
// itof_arbiter
// Shares one combinational int-to-float (itof) datapath between two
// requesters with round-robin arbitration and a 2-stage registered pipeline
// (operand capture in S1, converted result in S2). Results return in
// acceptance order on a single tagged valid/ready response channel.
//
// Ports:
//   clk, rstn                  clock (rising edge), async active-low reset
//   reqN_valid/ready           requester N operand handshake (N = 0, 1)
//   reqN_data [31:0]           signed two's-complement operand
//   reqN_tag  [TAG_W-1:0]      requester tag, returned with the result
//   resp_valid/ready           result handshake
//   resp_data [31:0]           IEEE-754 single-precision result
//   resp_tag  [TAG_W-1:0]      tag of the originating request
//   resp_src                   index of the originating requester
//   busy                       an operation is held in S1 or S2
`timescale 1ns/1ps

// Combinational signed int32 -> binary32, round to nearest even.
// Zero converts to +0.0.
module itof (
  input  logic [31:0] a,
  output logic [31:0] y
);
  logic        sign;
  logic [31:0] mag;
  logic [4:0]  msb;
  logic [31:0] norm;
  logic [22:0] mant;
  logic        guard;
  logic        sticky;
  logic [7:0]  expo;
  logic        rnd;
  logic [30:0] body;

  always_comb begin
    sign = a[31];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    mag  = sign ? (~a + 32'd1) : a;
    msb  = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    norm   = mag << (5'd31 - msb);
    mant   = norm[30:8];
    guard  = norm[7];
    sticky = |norm[6:0];
    expo   = 8'd127 + {3'b000, msb};
    rnd    = guard & (sticky | mant[0]);
    // A mantissa carry-out from rounding bumps the exponent for free.
    body   = {expo, mant} + {30'd0, rnd};
    y      = (mag == '0) ? '0 : {sign, body};
  end
endmodule

module itof_arbiter #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_data,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_data,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_src,
  output logic             busy
);
  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_data_q,  s1_data_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
  logic             s1_src_q,   s1_src_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_data_q,  s2_data_d;
  logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
  logic             s2_src_q,   s2_src_d;
  logic             rr_q,       rr_d;

  logic        adv1, adv2;
  logic        grant0, grant1;
  logic        acc0, acc1;
  logic [31:0] conv;

  itof u_itof (
    .a (s1_data_q),
    .y (conv)
  );

  always_comb begin
    adv2   = !s2_valid_q || resp_ready;
    adv1   = !s1_valid_q || adv2;
    grant0 = req0_valid && (!req1_valid || !rr_q);
    grant1 = req1_valid && (!req0_valid ||  rr_q);
    // Gated by rstn so no handshake can be signalled while reset is held.
    acc0   = grant0 && adv1 && rstn;
    acc1   = grant1 && adv1 && rstn;
  end

  assign req0_ready = acc0;
  assign req1_ready = acc1;
  assign resp_valid = s2_valid_q;
  assign resp_data  = s2_data_q;
  assign resp_tag   = s2_tag_q;
  assign resp_src   = s2_src_q;
  assign busy       = s1_valid_q | s2_valid_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_tag_d   = s1_tag_q;
    s1_src_d   = s1_src_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_tag_d   = s2_tag_q;
    s2_src_d   = s2_src_q;
    rr_d       = rr_q;

    if (acc0 || acc1) begin
      s1_valid_d = 1'b1;
      s1_data_d  = acc1 ? req1_data : req0_data;
      s1_tag_d   = acc1 ? req1_tag  : req0_tag;
      s1_src_d   = acc1;
    end else if (adv2) begin
      s1_valid_d = 1'b0;
    end

    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = conv;
        s2_tag_d  = s1_tag_q;
        s2_src_d  = s1_src_q;
      end
    end

    if (acc0)      rr_d = 1'b1;
    else if (acc1) rr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_tag_q   <= '0;
      s1_src_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
      s2_src_q   <= 1'b0;
      rr_q       <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_tag_q   <= s1_tag_d;
      s1_src_q   <= s1_src_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_tag_q   <= s2_tag_d;
      s2_src_q   <= s2_src_d;
      rr_q       <= rr_d;
    end
  end
endmodule

// File: tb/tb_itof_arbiter.sv
`timescale 1ns/1ps

module tb_itof_arbiter;
  localparam int unsigned TAG_W = 5;

  logic             clk = 1'b0;
  logic             rstn;
  logic             req0_valid, req0_ready;
  logic [31:0]      req0_data;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready;
  logic [31:0]      req1_data;
  logic [TAG_W-1:0] req1_tag;
  logic             resp_valid, resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_src;
  logic             busy;

  itof_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_data(req0_data), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_data(req1_data), .req1_tag(req1_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag),
    .resp_src(resp_src), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit lat_strict = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference conversion: go through the exact double value of the integer
  // and round its 52-bit fraction to 23 bits, nearest-even.
  function automatic logic [31:0] ref_itof(input logic [31:0] x);
    int          xi;
    real         r;
    logic [63:0] b;
    int          ee;
    logic [7:0]  e8;
    logic [22:0] m;
    logic [28:0] rem;
    logic [30:0] em;
    if (x == 32'd0) return 32'd0;
    xi  = x;
    r   = real'(xi);
    b   = $realtobits(r);
    ee  = int'(b[62:52]) - 1023 + 127;
    e8  = 8'(ee);
    m   = b[51:29];
    rem = b[28:0];
    em  = {e8, m};
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) em = em + 31'd1;
    return {b[63], em};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic [31:0]      d;
    logic [TAG_W-1:0] t;
    logic             s;
    int               c;
  } exp_t;

  exp_t sb[$];
  bit   rr_m;
  int   mcyc = 0;
  int   n;
  bit   e_adv, e_g0, e_g1;
  exp_t e;

  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
      rr_m = 1'b0;
    end else begin
      n     = sb.size();
      // With two ops in flight both stages are full; otherwise S1 can take one.
      e_adv = (n < 2) || resp_ready;
      e_g0  = req0_valid && (!req1_valid || rr_m == 1'b0);
      e_g1  = req1_valid && (!req0_valid || rr_m == 1'b1);
      chk("ready0", 32'(req0_ready), 32'(e_adv && e_g0));
      chk("ready1", 32'(req1_ready), 32'(e_adv && e_g1));
      chk("busy",   32'(busy),       32'(n != 0));
      if (resp_valid && resp_ready) begin
        if (n == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got data %h tag %h, expected no response", resp_data, resp_tag);
        end else begin
          e = sb.pop_front();
          chk("resp_data", resp_data,       e.d);
          chk("resp_tag",  32'(resp_tag),   32'(e.t));
          chk("resp_src",  32'(resp_src),   32'(e.s));
          if (lat_strict) chk("latency", 32'(mcyc - e.c), 32'd2);
        end
      end
      if (req0_valid && req0_ready) begin
        sb.push_back('{ref_itof(req0_data), req0_tag, 1'b0, mcyc});
        rr_m = 1'b1;
      end
      if (req1_valid && req1_ready) begin
        sb.push_back('{ref_itof(req1_data), req1_tag, 1'b1, mcyc});
        rr_m = 1'b0;
      end
      mcyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_data();
    logic [31:0] tbl [8];
    logic [31:0] v;
    tbl = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
            32'h7FFF_FFFF, 32'h00FF_FFFF, 32'h0100_0001, 32'h0100_0003};
    case ($urandom_range(0, 3))
      0:       v = $urandom;
      1:       v = 32'($urandom_range(0, 15)) - 32'd8;
      2:       v = tbl[$urandom_range(0, 7)];
      default: begin
        v = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) v = -v;
      end
    endcase
    return v;
  endfunction

  task automatic send_chk(input int r, input logic [31:0] d,
                          input logic [TAG_W-1:0] t, input logic [31:0] expd);
    bit ok = 1'b0;
    if (r == 0) begin req0_valid = 1'b1; req0_data = d; req0_tag = t; end
    else        begin req1_valid = 1'b1; req1_data = d; req1_tag = t; end
    for (int w = 0; w < 20 && !ok; w++) begin
      @(negedge clk);
      ok = (r == 0) ? req0_ready : req1_ready;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("send_accepted", 32'(ok), 32'd1);
    if (ok) begin
      chk("lat_s1_only", 32'(resp_valid), 32'd0);
      tick();
      chk("lat_resp_valid", 32'(resp_valid), 32'd1);
      chk("dir_data", resp_data, expd);
      chk("dir_tag",  32'(resp_tag), 32'(t));
      chk("dir_src",  32'(resp_src), 32'(r));
    end
    tick();
  endtask

  task automatic drain(input string nm);
    bit empty = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    for (int w = 0; w < 20 && !empty; w++) begin
      tick();
      empty = (sb.size() == 0) && !busy;
    end
    chk(nm, 32'(empty), 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sweep_in  [5];
    logic [31:0] sweep_out [5];
    int          grants    [6];
    int          g, w, acc;
    logic [31:0] held;
    bit          have_held;
    bit          a0, a1;
    int          ops, cyc;

    sweep_in  = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0003, 32'h8000_0000, 32'h7FFF_FFFF};
    sweep_out = '{32'hBF80_0000, 32'h0000_0000, 32'h4040_0000, 32'hCF00_0000, 32'h4F00_0000};

    // Reset state, with both requesters asking.
    rstn = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h1234_5678; req0_tag = '0;
    req1_valid = 1'b1; req1_data = 32'h8765_4321; req1_tag = '0;
    resp_ready = 1'b1;
    #3;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data",  resp_data,        32'd0);
    chk("rst_resp_tag",   32'(resp_tag),    32'd0);
    chk("rst_resp_src",   32'(resp_src),    32'd0);
    chk("rst_busy",       32'(busy),        32'd0);
    chk("rst_ready0",     32'(req0_ready),  32'd0);
    chk("rst_ready1",     32'(req1_ready),  32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Single request and value sweep.
    lat_strict = 1'b1;
    send_chk(0, 32'h0000_0001, 5'd3, 32'h3F80_0000);
    for (int i = 0; i < 5; i++) send_chk(1, sweep_in[i], 5'(i + 8), sweep_out[i]);

    // Contention right after reset: strict alternation starting at 0.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    req0_valid = 1'b1; req0_data = rnd_data(); req0_tag = 5'd1;
    req1_valid = 1'b1; req1_data = rnd_data(); req1_tag = 5'd2;
    g = 0;
    w = 0;
    while (g < 6 && w < 50) begin
      @(negedge clk);
      a0 = req0_ready;
      a1 = req1_ready;
      if (a0) begin grants[g] = 0; g++; end
      if (a1) begin grants[g] = 1; g++; end
      w++;
      tick();
      if (a0) begin req0_data = rnd_data(); req0_tag = 5'($urandom); end
      if (a1) begin req1_data = rnd_data(); req1_tag = 5'($urandom); end
      if (g >= 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    chk("contention_grants", 32'(g), 32'd6);
    chk("contention_cycles", 32'(w), 32'd6);
    for (int i = 0; i < 6 && i < g; i++) chk("grant_order", 32'(grants[i]), 32'(i % 2));
    drain("contention_drain");
    lat_strict = 1'b0;

    // Backpressure: req0 streams for 5 cycles with resp_ready low.
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_data = rnd_data(); req0_tag = 5'($urandom);
    acc = 0;
    have_held = 1'b0;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a0 = req0_ready;
      if (a0) acc++;
      if (resp_valid) begin
        if (have_held) chk("stall_data_stable", resp_data, held);
        held = resp_data;
        have_held = 1'b1;
      end
      tick();
      if (a0) begin req0_data = rnd_data(); req0_tag = 5'($urandom); end
    end
    @(negedge clk);
    chk("bp_accepted", 32'(acc), 32'd2);
    chk("bp_ready0_low", 32'(req0_ready), 32'd0);
    chk("bp_have_resp", 32'(have_held), 32'd1);
    tick();
    drain("bp_drain");

    // Reset with both stages full.
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_data = rnd_data(); req0_tag = 5'($urandom);
    w = 0;
    while (!(resp_valid && busy && !req0_ready) && w < 10) begin
      @(negedge clk);
      a0 = req0_ready;
      tick();
      if (a0) req0_data = rnd_data();
      w++;
    end
    chk("fill_both_stages", 32'(resp_valid && !req0_ready), 32'd1);
    req1_valid = 1'b1; req1_data = rnd_data(); req1_tag = 5'($urandom);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_busy",       32'(busy),       32'd0);
    chk("midrst_ready0",     32'(req0_ready), 32'd0);
    chk("midrst_ready1",     32'(req1_ready), 32'd0);
    tick();
    #2;
    rstn = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("midrst_first_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick();
    drain("midrst_drain");

    // Random traffic.
    ops = 0;
    cyc = 0;
    while (ops < 10000 && cyc < 80000) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      ops += int'(a0) + int'(a1);
      tick();
      if (!req0_valid || a0) begin
        req0_valid = ($urandom_range(0, 9) < 6);
        req0_data  = rnd_data();
        req0_tag   = 5'($urandom);
      end
      if (!req1_valid || a1) begin
        req1_valid = ($urandom_range(0, 9) < 6);
        req1_data  = rnd_data();
        req1_tag   = 5'($urandom);
      end
      resp_ready = ($urandom_range(0, 9) < 7);
      cyc++;
    end
    chk("random_ops_done", 32'(ops >= 10000), 32'd1);
    drain("random_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
